iter_muldiv_unit: RTL

Parametrised sequential multiply/divide unit. It replaces the single-cycle combinational MULTIPLY/DIVIDE paths in the processor ALU with a shift-add / restoring-divide engine of WIDTH iterations. It supports signed and unsigned operands, returns a full double-width product or a quotient/remainder pair, and flags divide-by-zero. It sits beside the ALU in the execute stage: the processor asserts `start`, stalls while `busy` is high, and captures the result on `done`.

---
 rtl/iter_muldiv_unit.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/iter_muldiv_unit.sv
// -----------------------------------------------------------------------------
// iter_muldiv_unit
//   Sequential multiply/divide engine for the execute stage. A shift-add
//   multiplier and a restoring divider share one accumulator pair and retire
//   one bit per cycle over WIDTH cycles. Operands are converted to magnitudes
//   on acceptance, and the signs are re-applied when the result is written.
//
// Ports
//   CLK          clock, rising edge
//   reset_n      asynchronous active-low reset
//   start        request, sampled in IDLE/DONE only
//   op[0]        0 = MUL, 1 = DIV
//   op[1]        0 = unsigned, 1 = signed (two's complement)
//   a, b         multiplicand/dividend, multiplier/divisor
//   busy         high while iterating
//   done         one-cycle pulse when results are valid
//   result_hi    MUL: product upper half, DIV: remainder
//   result_lo    MUL: product lower half, DIV: quotient
//   div_by_zero  set by DIV with b = 0, cleared by the next accepted start
// -----------------------------------------------------------------------------
module iter_muldiv_unit #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_hi,
    output logic [WIDTH-1:0] result_lo,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // Operation context captured at the accepting edge; inputs are free after.
    typedef struct packed {
        logic             div;
        logic             neg_q;   // sign of product / quotient
        logic             neg_r;   // sign of remainder (follows dividend)
        logic [WIDTH-1:0] mag_a;
        logic [WIDTH-1:0] mag_b;
        logic [WIDTH-1:0] raw_a;   // returned unchanged on divide-by-zero
    } ctx_t;

    state_t           state, nstate;
    ctx_t             ctx;
    logic [CW-1:0]    cnt;
    // acc_hi carries one guard bit: the multiplier's carry-out and the
    // divider's shifted partial remainder both need WIDTH+1 bits.
    logic [WIDTH:0]   acc_hi;
    logic [WIDTH-1:0] acc_lo;

    logic             accept, last, dz_run;
    logic             sa, sb;
    logic [WIDTH-1:0] mag_a_in, mag_b_in;
    logic [WIDTH:0]   mul_sum, div_sh, div_tr;
    logic [WIDTH:0]   nxt_hi;
    logic [WIDTH-1:0] nxt_lo;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0] quo_fix, rem_fix;

    assign busy   = (state == RUN);
    assign done   = (state == DONE);
    assign accept = (state != RUN) && start;
    assign last   = (cnt == CW'(WIDTH - 1));
    assign dz_run = ctx.div && (ctx.mag_b == '0);

    // Magnitudes at the input; -(most negative) wraps to 2^(WIDTH-1), which
    // is the correct unsigned magnitude.
    always_comb begin
        sa       = op[1] & a[WIDTH-1];
        sb       = op[1] & b[WIDTH-1];
        mag_a_in = sa ? -a : a;
        mag_b_in = sb ? -b : b;
    end

    // One iteration step plus sign correction of its outcome.
    always_comb begin
        mul_sum = acc_hi + (acc_lo[0] ? {1'b0, ctx.mag_a} : '0);
        div_sh  = {acc_hi[WIDTH-1:0], acc_lo[WIDTH-1]};
        div_tr  = div_sh - {1'b0, ctx.mag_b};
        if (ctx.div) begin
            // A clear top bit after the trial subtract means no borrow.
            if (!div_tr[WIDTH]) begin
                nxt_hi = div_tr;
                nxt_lo = {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
                nxt_hi = div_sh;
                nxt_lo = {acc_lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            nxt_hi = {1'b0, mul_sum[WIDTH:1]};
            nxt_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
        end
        prod     = {nxt_hi[WIDTH-1:0], nxt_lo};
        prod_fix = ctx.neg_q ? -prod : prod;
        quo_fix  = ctx.neg_q ? -nxt_lo : nxt_lo;
        rem_fix  = ctx.neg_r ? -nxt_hi[WIDTH-1:0] : nxt_hi[WIDTH-1:0];
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= nstate;
    end

    always_comb begin
        nstate = state;
        case (state)
            IDLE, DONE: nstate = start ? RUN : IDLE;
            RUN:        if (dz_run || last) nstate = DONE;
            default:    nstate = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            ctx         <= '0;
            cnt         <= '0;
            acc_hi      <= '0;
            acc_lo      <= '0;
            result_hi   <= '0;
            result_lo   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            ctx.div     <= op[0];
            ctx.neg_q   <= sa ^ sb;
            ctx.neg_r   <= sa;
            ctx.mag_a   <= mag_a_in;
            ctx.mag_b   <= mag_b_in;
            ctx.raw_a   <= a;
            cnt         <= '0;
            acc_hi      <= '0;
            // Multiplier shifts out of acc_lo; dividend shifts out of acc_lo.
            acc_lo      <= op[0] ? mag_a_in : mag_b_in;
            div_by_zero <= 1'b0;
        end else if (state == RUN) begin
            if (dz_run) begin
                result_lo   <= '1;
                result_hi   <= ctx.raw_a;
                div_by_zero <= 1'b1;
            end else begin
                acc_hi <= nxt_hi;
                acc_lo <= nxt_lo;
                cnt    <= cnt + 1'b1;
                if (last) begin
                    if (ctx.div) begin
                        result_lo <= quo_fix;
                        result_hi <= rem_fix;
                    end else begin
                        {result_hi, result_lo} <= prod_fix;
                    end
                end
            end
        end
    end

endmodule
